// File: rtl/morra_pkg.sv
// morra_pkg: shared move, result and state types for the Morra Cinese controller
package morra_pkg;
  typedef enum logic [1:0] {NONE = 2'b00, SASSO = 2'b01, CARTA = 2'b10, FORBICE = 2'b11} move_t;
  typedef enum logic [1:0] {R_NONE = 2'b00, P1 = 2'b01, P2 = 2'b10, DRAW = 2'b11} res_t;
  typedef enum logic [1:0] {IDLE = 2'b00, PLAY = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/morra_judge.sv
// morra_judge: combinational referee for one manche (result plus both-moves-present flag)
module morra_judge
  import morra_pkg::*;
(
  input  move_t a,
  input  move_t b,
  output res_t  res,
  output logic  both
);
  logic a_wins;
  // Decide the manche from the beats relation; a missing move yields no result
  always_comb begin
    both   = (a != NONE) && (b != NONE);
    a_wins = (a == CARTA && b == SASSO) || (a == SASSO && b == FORBICE) || (a == FORBICE && b == CARTA);
    res    = !both ? R_NONE : (a == b) ? DRAW : a_wins ? P1 : P2;
  end
endmodule

// File: rtl/morra_cinese_param.sv
// morra_cinese_param: parametrised rock-paper-scissors match controller; MORRA_NOREPEAT_EN enables the no-repeat rule
module morra_cinese_param
  import morra_pkg::*;
#(
  parameter int MIN_ROUNDS = 4,
  parameter int LEAD       = 2,
  parameter int ROUND_W    = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               INIZIO,
  input  logic               VALID,
  input  logic [1:0]         PRIMO,
  input  logic [1:0]         SECONDO,
  output logic [1:0]         MANCHE,
  output logic [1:0]         PARTITA,
  output logic [ROUND_W-1:0] SCORE1,
  output logic [ROUND_W-1:0] SCORE2,
  output logic [ROUND_W-1:0] ROUND
);
  state_t             st;
  res_t               manche, partita, res, pres;
  logic               both, blocked, ok, margin, fin;
  logic [ROUND_W-1:0] limit, score1, score2, round, n_s1, n_s2, n_r, diff;
`ifdef MORRA_NOREPEAT_EN
  res_t  last_win;
  move_t last_mv;
`endif
  morra_judge u_judge (.a(move_t'(PRIMO)), .b(move_t'(SECONDO)), .res(res), .both(both));
  // Qualify the manche and precompute post-update counters and match verdict
  always_comb begin
`ifdef MORRA_NOREPEAT_EN
    blocked = (last_win == P1 && move_t'(PRIMO) == last_mv) || (last_win == P2 && move_t'(SECONDO) == last_mv);
`else
    blocked = 1'b0;
`endif
    ok     = (st == PLAY) && VALID && both && !blocked;
    n_s1   = score1 + ROUND_W'(res == P1);
    n_s2   = score2 + ROUND_W'(res == P2);
    n_r    = round + 1'b1;
    diff   = (n_s1 > n_s2) ? n_s1 - n_s2 : n_s2 - n_s1;
    margin = (diff >= ROUND_W'(LEAD)) && (n_r >= ROUND_W'(MIN_ROUNDS));
    fin    = margin || (n_r == limit);
    pres   = (n_s1 > n_s2) ? P1 : (n_s2 > n_s1) ? P2 : margin ? P2 : DRAW;
  end
  // Match sequencing: reset, start/restart, then one scored manche per qualified move cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st      <= IDLE;
      manche  <= R_NONE;
      partita <= R_NONE;
      limit   <= '0;
      score1  <= '0;
      score2  <= '0;
      round   <= '0;
`ifdef MORRA_NOREPEAT_EN
      last_win <= R_NONE;
      last_mv  <= NONE;
`endif
    end else if (INIZIO) begin
      st      <= PLAY;
      manche  <= R_NONE;
      partita <= R_NONE;
      limit   <= ROUND_W'(MIN_ROUNDS) + ROUND_W'({PRIMO, SECONDO});
      score1  <= '0;
      score2  <= '0;
      round   <= '0;
`ifdef MORRA_NOREPEAT_EN
      last_win <= R_NONE;
      last_mv  <= NONE;
`endif
    end else begin
      manche <= ok ? res : R_NONE;
      if (ok) begin
        round  <= n_r;
        score1 <= n_s1;
        score2 <= n_s2;
        if (fin) begin
          partita <= pres;
          st      <= DONE;
        end
`ifdef MORRA_NOREPEAT_EN
        last_win <= (res == DRAW) ? R_NONE : res;
        last_mv  <= (res == P1) ? move_t'(PRIMO) : move_t'(SECONDO);
`endif
      end
    end
  end
  assign MANCHE  = manche;
  assign PARTITA = partita;
  assign SCORE1  = score1;
  assign SCORE2  = score2;
  assign ROUND   = round;
endmodule

// File: tb/tb_morra_cinese_param.sv
// tb_morra_cinese_param: vector table, hand sequences and random play against a rule-level model
module tb_morra_cinese_param;
  localparam int MINR = 4;
  localparam int LD   = 2;
  localparam int W    = 5;

  logic         clk = 0;
  logic         rst_n = 0, ini = 0, v = 0;
  logic [1:0]   p = 0, s = 0;
  logic [1:0]   manche, partita;
  logic [W-1:0] sc1, sc2, rnd;
  int total = 0, bad = 0;

  int m_man, m_par, m_s1, m_s2, m_r, m_lim, m_st, m_lw, m_lm;

  morra_cinese_param #(.MIN_ROUNDS(MINR), .LEAD(LD), .ROUND_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .INIZIO(ini), .VALID(v), .PRIMO(p), .SECONDO(s),
    .MANCHE(manche), .PARTITA(partita), .SCORE1(sc1), .SCORE2(sc2), .ROUND(rnd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rn, in, vl;
    logic [1:0] pp, ss;
    int em, ep, e1, e2, er;
  } vec_t;

`ifdef MORRA_NOREPEAT_EN
  localparam bit NOREP = 1'b1;
`else
  localparam bit NOREP = 1'b0;
`endif

  function automatic bit beats(int a, int b);
    return ((a - b + 3) % 3) == 1;
  endfunction

  task automatic model(input logic rn, input logic in, input logic vl, input int a, input int b);
    int w, d;
    if (!rn) begin
      m_man = 0; m_par = 0; m_s1 = 0; m_s2 = 0; m_r = 0; m_lim = 0; m_st = 0; m_lw = 0; m_lm = 0;
    end else if (in) begin
      m_lim = MINR + a * 4 + b;
      m_man = 0; m_par = 0; m_s1 = 0; m_s2 = 0; m_r = 0; m_st = 1; m_lw = 0; m_lm = 0;
    end else begin
      m_man = 0;
      if (m_st == 1 && vl && a != 0 && b != 0 &&
          !(NOREP && m_lw != 0 && ((m_lw == 1) ? a : b) == m_lm)) begin
        w = (a == b) ? 3 : beats(a, b) ? 1 : 2;
        m_r++;
        if (w == 1) m_s1++;
        if (w == 2) m_s2++;
        m_man = w;
        m_lw = (w == 3) ? 0 : w;
        m_lm = (w == 1) ? a : b;
        d = (m_s1 > m_s2) ? m_s1 - m_s2 : m_s2 - m_s1;
        if (d >= LD && m_r >= MINR) begin
          m_par = (m_s1 > m_s2) ? 1 : 2; m_st = 2;
        end else if (m_r == m_lim) begin
          m_par = (m_s1 > m_s2) ? 1 : (m_s2 > m_s1) ? 2 : 3; m_st = 2;
        end
      end
    end
  endtask

  task automatic chk(input string n, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", n, got, exp);
    end
  endtask

  task automatic step(input logic rn, input logic in, input logic vl, input logic [1:0] a, input logic [1:0] b, input string tag);
    rst_n = rn; ini = in; v = vl; p = a; s = b;
    @(posedge clk); #1;
    model(rn, in, vl, int'(a), int'(b));
    chk({tag, ".manche"}, int'(manche), m_man);
    chk({tag, ".partita"}, int'(partita), m_par);
    chk({tag, ".score1"}, int'(sc1), m_s1);
    chk({tag, ".score2"}, int'(sc2), m_s2);
    chk({tag, ".round"}, int'(rnd), m_r);
  endtask

  vec_t tbl[$];

  task automatic add(input logic rn, input logic in, input logic vl, input logic [1:0] a, input logic [1:0] b,
                     input int em, input int ep, input int e1, input int e2, input int er);
    vec_t t;
    t.rn = rn; t.in = in; t.vl = vl; t.pp = a; t.ss = b;
    t.em = em; t.ep = ep; t.e1 = e1; t.e2 = e2; t.er = er;
    tbl.push_back(t);
  endtask

  initial begin
    add(0, 0, 1, 2, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 1, 0, 1, 0, 1);
    add(1, 0, 1, 1, 3, 1, 0, 2, 0, 2);
    add(1, 0, 1, 2, 1, 1, 0, 3, 0, 3);
    add(1, 0, 1, 1, 3, 1, 1, 4, 0, 4);
    add(1, 0, 1, 2, 1, 0, 1, 4, 0, 4);
    add(1, 0, 0, 0, 0, 0, 1, 4, 0, 4);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 1, 0, 1, 0, 1);
    add(1, 0, 1, 1, 3, 1, 0, 2, 0, 2);
    add(1, 0, 1, 2, 3, 2, 0, 2, 1, 3);
    add(1, 0, 1, 1, 2, 2, 3, 2, 2, 4);
    add(1, 1, 0, 3, 3, 0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 2, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 3, 0, 0, 0, 1);
    add(1, 0, 0, 2, 1, 0, 0, 0, 0, 1);
    add(1, 0, 1, 2, 1, 1, 0, 1, 0, 2);
    add(1, 0, 1, 1, 2, 2, 0, 1, 1, 3);
    add(1, 0, 1, 1, 3, 1, 0, 2, 1, 4);
    add(1, 0, 1, 2, 3, 2, 0, 2, 2, 5);
    add(1, 0, 1, 3, 2, 1, 0, 3, 2, 6);
    add(1, 0, 1, 2, 1, 1, 1, 4, 2, 7);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 1, 0, 1, 0, 1);
    add(1, 1, 1, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 1, 1, 1, 3, 0, 0, 0, 1);
    add(1, 0, 1, 2, 2, 3, 0, 0, 0, 2);
    add(1, 0, 1, 3, 3, 3, 0, 0, 0, 3);
    add(1, 0, 1, 1, 1, 3, 0, 0, 0, 4);
    add(1, 0, 1, 2, 2, 3, 3, 0, 0, 5);
    add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 1, 0, 1, 0, 1);
    add(0, 0, 1, 1, 3, 0, 0, 0, 0, 0);
    add(1, 0, 1, 2, 1, 0, 0, 0, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].rn, tbl[i].in, tbl[i].vl, tbl[i].pp, tbl[i].ss, $sformatf("vec%0d", i));
      chk($sformatf("tbl%0d.manche", i), int'(manche), tbl[i].em);
      chk($sformatf("tbl%0d.partita", i), int'(partita), tbl[i].ep);
      chk($sformatf("tbl%0d.score1", i), int'(sc1), tbl[i].e1);
      chk($sformatf("tbl%0d.score2", i), int'(sc2), tbl[i].e2);
      chk($sformatf("tbl%0d.round", i), int'(rnd), tbl[i].er);
    end

    step(1, 1, 0, 0, 0, "nr_start");
    step(1, 0, 1, 2, 1, "nr_win");
    step(1, 0, 1, 2, 3, "nr_repeat");
    chk("nr_repeat.manche_fixed", int'(manche), NOREP ? 0 : 2);
    chk("nr_repeat.round_fixed", int'(rnd), NOREP ? 1 : 2);
    step(1, 0, 1, 2, 2, "nr_draw");
    step(1, 0, 1, 2, 1, "nr_after_draw");
    chk("nr_after_draw.manche_fixed", int'(manche), 1);

    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 60) != 0), ($urandom_range(0, 14) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
